// File: rtl/indent_lane_monitor.sv
// indent_lane_monitor: synchronises NUM_LANES asynchronous lane levels, counts
// their edges (saturating), and posts each edge as a single event on a
// valid/ready port. Lanes are served round-robin. A lane that sees a new edge
// while its previous edge is still waiting loses the new edge and raises a
// sticky overflow flag.
module indent_lane_monitor #(
  parameter int NUM_LANES   = 4,
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2,
  localparam int LW         = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_LANES-1:0]       y_i,
  input  logic                       clr_i,
  output logic                       evt_valid_o,
  input  logic                       evt_ready_i,
  output logic [LW-1:0]              evt_lane_o,
  output logic                       evt_rise_o,
  output logic [NUM_LANES*CNT_W-1:0] cnt_o,
  output logic [NUM_LANES-1:0]       ovf_o
);

  logic [SYNC_STAGES-1:0][NUM_LANES-1:0] sync_q, sync_d;
  logic [NUM_LANES-1:0]                  prev_q, prev_d;
  logic [NUM_LANES-1:0]                  pend_q, pend_d;
  logic [NUM_LANES-1:0]                  pol_q, pol_d;
  logic [NUM_LANES-1:0]                  ovf_q, ovf_d;
  logic [NUM_LANES-1:0][CNT_W-1:0]       cnt_q, cnt_d;
  logic [LW-1:0]                         ptr_q, ptr_d;
  logic [LW-1:0]                         lane_q, lane_d;
  logic                                  valid_q, valid_d;
  logic                                  rise_q, rise_d;

  logic [NUM_LANES-1:0] sync_s;
  logic [NUM_LANES-1:0] edg;
  logic [NUM_LANES-1:0] drain;
  logic [LW-1:0]        gnt;
  logic [LW-1:0]        cand;
  logic                 found;
  logic                 load;
  int                   idx;

  // Input synchroniser chain plus previous-level register for edge detection.
  always_comb begin
    sync_d[0] = y_i;
    for (int k = 1; k < SYNC_STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
  end

  assign sync_s = sync_q[SYNC_STAGES-1];
  assign prev_d = sync_s;
  assign edg    = sync_s ^ prev_q;

  // Round-robin search: first pending lane at or after the pointer, wrapping.
  always_comb begin
    found = 1'b0;
    gnt   = '0;
    idx   = 0;
    cand  = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      idx  = (int'(ptr_q) + i) % NUM_LANES;
      cand = LW'(idx);
      if (!found && pend_q[cand]) begin
        found = 1'b1;
        gnt   = cand;
      end
    end
  end

  // The output register may take a new event when empty or when being accepted.
  assign load  = !valid_q || evt_ready_i;
  assign drain = (load && found) ? (NUM_LANES'(1) << gnt) : '0;

  // Output register and pointer update.
  always_comb begin
    valid_d = valid_q;
    lane_d  = lane_q;
    rise_d  = rise_q;
    ptr_d   = ptr_q;
    if (load) begin
      valid_d = found;
      if (found) begin
        lane_d = gnt;
        rise_d = pol_q[gnt];
        ptr_d  = (gnt == LW'(NUM_LANES - 1)) ? '0 : gnt + 1'b1;
      end
    end
  end

  // Per-lane pending slot, overflow flag and saturating counter.
  always_comb begin
    pend_d = pend_q;
    pol_d  = pol_q;
    ovf_d  = ovf_q;
    cnt_d  = cnt_q;
    for (int n = 0; n < NUM_LANES; n++) begin
      if (drain[n]) begin
        pend_d[n] = 1'b0;
      end
      if (edg[n]) begin
        // A slot being drained this cycle is free for the new edge.
        if (!pend_q[n] || drain[n]) begin
          pend_d[n] = 1'b1;
          pol_d[n]  = sync_s[n];
        end else begin
          ovf_d[n] = 1'b1;
        end
      end
      // Clear wins over a same-cycle edge; the event itself is still posted.
      if (clr_i) begin
        cnt_d[n] = '0;
        ovf_d[n] = 1'b0;
      end else if (edg[n] && (cnt_q[n] != '1)) begin
        cnt_d[n] = cnt_q[n] + 1'b1;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      prev_q  <= '0;
      pend_q  <= '0;
      pol_q   <= '0;
      ovf_q   <= '0;
      cnt_q   <= '0;
      ptr_q   <= '0;
      lane_q  <= '0;
      valid_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      pend_q  <= pend_d;
      pol_q   <= pol_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      lane_q  <= lane_d;
      valid_q <= valid_d;
      rise_q  <= rise_d;
    end
  end

  assign evt_valid_o = valid_q;
  assign evt_lane_o  = lane_q;
  assign evt_rise_o  = rise_q;
  assign cnt_o       = cnt_q;
  assign ovf_o       = ovf_q;

endmodule

// File: doc/indent_lane_monitor.md
Name: indent_lane_monitor

Overview:
- Downstream consumer of the four per-lane `subindent` instances generated in `indent`. It takes their `y` outputs as asynchronous lane inputs.
- For each lane it synchronises the input, detects rising and falling edges, and keeps a saturating edge counter.
- Detected edges are posted as one-at-a-time events on a valid/ready interface, selected round-robin across lanes.
- A per-lane sticky overflow flag records any edge lost while that lane already had an event waiting.

Parameters:
- NUM_LANES, 4, number of lanes monitored; must be ≥2.
- CNT_W, 8, width of each per-lane edge counter.
- SYNC_STAGES, 2, flops in each input synchroniser; must be ≥2.

Ports:
- clk  input  1  single clock for all logic.
- rst_n  input  1  asynchronous active-low reset. Assertion is asynchronous; deassertion is expected synchronous to clk.
- y_i  input  NUM_LANES  lane levels from the subindent instances; asynchronous to clk.
- clr_i  input  1  synchronous clear of all counters and overflow flags.
- evt_valid_o  output  1  an event is presented.
- evt_ready_i  input  1  consumer accepts the event.
- evt_lane_o  output  $clog2(NUM_LANES)  lane index of the presented event.
- evt_rise_o  output  1  1 = rising edge, 0 = falling edge.
- cnt_o  output  NUM_LANES*CNT_W  per-lane edge counts; lane n occupies bits [n*CNT_W +: CNT_W].
- ovf_o  output  NUM_LANES  per-lane sticky overflow flags.

Behaviour:
- Reset:
  - Synchroniser flops, previous-level registers, pending bits, pending polarity, evt_valid_o, evt_lane_o, evt_rise_o, cnt_o and ovf_o all reset to 0.
  - The round-robin pointer resets so that lane 0 has highest priority.
  - Reset mid-operation discards any pending or presented event immediately.
- Synchronise and edge detect:
  - Each lane passes through a SYNC_STAGES flop chain giving sync[n].
  - prev[n] registers sync[n] every cycle.
  - An edge on lane n is sync[n] != prev[n]. Its polarity is rise = sync[n].
  - Because all flops reset to 0, a lane held high through reset produces one rising edge after reset release.
- Counters:
  - cnt[n] increments by 1 on every detected edge and saturates at 2^CNT_W-1 (it never wraps).
  - clr_i has priority: the counter becomes 0, and an edge in the same cycle is not counted.
  - The event for that edge is still posted.
- Pending stage:
  - One pending bit plus a stored polarity per lane.
  - An edge on lane n with pend[n]=0 sets pend[n] and stores its polarity.
  - An edge with pend[n]=1 that is not being drained in that cycle keeps the stored (older) polarity, drops the new edge, and sets ovf[n].
  - If pend[n] is drained into the output register in the same cycle as a new edge, the new edge sets pend[n] again with no overflow.
  - clr_i clears ovf; clr_i does not clear pend.
- Arbiter and output register:
  - The output register loads when evt_valid_o=0, or when evt_valid_o=1 and evt_ready_i=1 (zero-bubble).
  - On load with any pend set, the register selects the first pending lane at or after the pointer, in increasing index with wrap.
  - On load it sets evt_valid_o=1, drives evt_lane_o and evt_rise_o, clears that lane's pend bit, and moves the pointer to the granted lane+1 mod NUM_LANES.
  - On load with no pend set, evt_valid_o goes to 0.
  - While evt_valid_o=1 and evt_ready_i=0, evt_lane_o and evt_rise_o hold stable and the pointer does not move.
- Latency:
  - An idle input level change that meets setup before clock edge 0 gives evt_valid_o=1 after edge SYNC_STAGES+1.
  - With SYNC_STAGES=2 that is after edge 3.
  - cnt_o updates one cycle before evt_valid_o.
- Throughput: one event per cycle when evt_ready_i is held high.

Test Plan:
- Reset with y_i=0, then raise y_i[2] and hold evt_ready_i=1 → evt_valid_o=1 after edge 3 for one cycle with evt_lane_o=2 and evt_rise_o=1; cnt lane2=1; ovf_o=0.
- Raise all four lanes in one cycle with evt_ready_i=1 → four consecutive events with lanes 0,1,2,3, all rise=1; each count=1.
  - Then drop all four lanes → events 0,1,2,3 with rise=0; each count=2.
- Hold evt_ready_i=0, then toggle lane 1 rise, fall, rise (two cycles apart):
  - The first rise is presented and held stable, and a later edge becomes pending.
  - At least one edge is dropped, giving ovf_o[1]=1 and cnt lane1=3.
  - Release ready → the held and pending events drain in order; ovf_o[1] stays 1 until clr_i.
- CNT_W=8: drive 300 edges on lane 0 with ready=1 → cnt lane0 saturates at 255.
  - Pulse clr_i → 0.
  - An edge coincident with clr_i → count stays 0 and the event is still emitted.
- Hold lanes 0 and 3 pending continuously with ready=1 → grants alternate 0,3,0,3 (no starvation).
- Assert rst_n=0 while evt_valid_o=1 with lanes pending → all outputs read 0 immediately; no events after release until new edges arrive.
